discharge_pulse_scheduler: RTL and testbench

//  Sequences the EDM discharge cycle in the clk_100M domain. Arbitrates start/stop requests from the SPI and key paths.

---
 rtl/discharge_pkg.sv | 18 +
 rtl/discharge_pulse_scheduler_phase_timer.sv | 53 +++++
 rtl/discharge_pulse_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_discharge_pulse_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/discharge_pkg.sv
// Shared definitions for the EDM discharge pulse scheduler.
package discharge_pkg;

  localparam int unsigned PARAM_W = 16;

  // Bit positions inside the pending vector {wave,ip,toff,ton}
  localparam int unsigned PEND_TON  = 0;
  localparam int unsigned PEND_TOFF = 1;
  localparam int unsigned PEND_IP   = 2;
  localparam int unsigned PEND_WAVE = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

endpackage

// File: rtl/discharge_pulse_scheduler_phase_timer.sv
// Phase timer: prescaler (0..TICK_DIV-1) feeding a 16-bit tick counter.
// A load latches the phase length and restarts counting; o_done is high in
// the last clock of a phase lasting i_len*TICK_DIV clocks.
module phase_timer
  import discharge_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [PARAM_W-1:0] i_len,
  input  logic               i_clear,
  output logic               o_done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]      r_presc;
  logic [PARAM_W-1:0] r_ticks;
  logic [PARAM_W-1:0] r_len;
  logic               w_presc_last;
  logic [PARAM_W:0]   w_ticks_inc;

  assign w_presc_last = (r_presc == PRESC_LAST);
  assign w_ticks_inc  = {1'b0, r_ticks} + {{PARAM_W{1'b0}}, 1'b1};
  // A zero length ends after a single tick instead of wrapping the counter
  assign o_done       = w_presc_last && (w_ticks_inc >= {1'b0, r_len});

  // Prescaler and tick counter, restarted on load or clear
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear || i_load) begin
      r_presc <= '0;
      r_ticks <= '0;
    end else if (w_presc_last) begin
      r_presc <= '0;
      r_ticks <= r_ticks + PARAM_W'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Phase length captured at phase entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len <= '0;
    end else if (i_load) begin
      r_len <= i_len;
    end
  end

endmodule

// File: rtl/discharge_pulse_scheduler.sv
// EDM discharge pulse scheduler: start/stop arbitration, double-buffered
// Ton/Toff/Ip/waveform parameters applied at pulse-cycle boundaries, and
// ON/OFF phase sequencing.
// Optional feature macro: SHORT_ABORT_EN (short_flag ends the ON phase early).
module discharge_pulse_scheduler
  import discharge_pkg::*;
#(
  parameter int unsigned        TICK_DIV = 100,
  parameter logic [PARAM_W-1:0] DEF_TON  = 16'd5,
  parameter logic [PARAM_W-1:0] DEF_TOFF = 16'd20,
  parameter logic [PARAM_W-1:0] DEF_IP   = 16'd0,
  parameter logic [PARAM_W-1:0] DEF_WAVE = 16'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_spi,
  input  logic               stop_spi,
  input  logic               start_key,
  input  logic               stop_key,
  input  logic               upd_ton,
  input  logic [PARAM_W-1:0] ton_in,
  input  logic               upd_toff,
  input  logic [PARAM_W-1:0] toff_in,
  input  logic               upd_ip,
  input  logic [PARAM_W-1:0] ip_in,
  input  logic               upd_wave,
  input  logic [PARAM_W-1:0] wave_in,
  input  logic               short_flag,
  output logic               gate_on,
  output logic               pulse_start,
  output logic               running,
  output logic [PARAM_W-1:0] active_ton,
  output logic [PARAM_W-1:0] active_toff,
  output logic [PARAM_W-1:0] active_ip,
  output logic [PARAM_W-1:0] active_wave,
  output logic [3:0]         pending,
  output logic [PARAM_W-1:0] pulse_cnt,
  output logic               param_err
);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PARAM_W-1:0] r_active_ton, r_active_toff, r_active_ip, r_active_wave;
  logic [PARAM_W-1:0] r_shadow_ton, r_shadow_toff, r_shadow_ip, r_shadow_wave;
  logic [3:0]         r_pending;
  logic [PARAM_W-1:0] r_pulse_cnt;
  logic               r_pulse_start;
  logic               r_param_err;

  logic               w_start_req;
  logic               w_stop_req;
  logic               w_short_abort;
  logic               w_timer_done;
  logic               w_load;
  logic               w_clear;
  logic [PARAM_W-1:0] w_load_len;
  logic               w_enter_on;
  logic               w_apply;
  logic               w_param_err_nxt;
  logic [3:0]         w_upd;
  logic [PARAM_W-1:0] w_eff_ton;
  logic [PARAM_W-1:0] w_eff_toff;

  assign w_start_req = start_spi | start_key;
  assign w_stop_req  = stop_spi | stop_key;
  assign w_upd       = {upd_wave, upd_ip, upd_toff, upd_ton};

`ifdef SHORT_ABORT_EN
  assign w_short_abort = short_flag;
`else
  assign w_short_abort = short_flag & 1'b0;
`endif

  // Values that will be in force once pending shadows are applied
  assign w_eff_ton  = r_pending[PEND_TON]  ? r_shadow_ton  : r_active_ton;
  assign w_eff_toff = r_pending[PEND_TOFF] ? r_shadow_toff : r_active_toff;

  // Apply pending shadows every IDLE clock and at each ON entry
  assign w_apply = (r_state == ST_IDLE) || w_enter_on;

  phase_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_phase_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_len   (w_load_len),
    .i_clear (w_clear),
    .o_done  (w_timer_done)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic, timer control and start validation
  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_load_len      = w_eff_ton;
    w_clear         = 1'b0;
    w_enter_on      = 1'b0;
    w_param_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (w_start_req && !w_stop_req) begin
          if ((w_eff_ton != '0) && (w_eff_toff != '0)) begin
            w_state_nxt = ST_ON;
            w_load      = 1'b1;
            w_load_len  = w_eff_ton;
            w_enter_on  = 1'b1;
          end else begin
            w_param_err_nxt = 1'b1;
          end
        end
      end
      ST_ON: begin
        if (w_stop_req) begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end else if (w_timer_done || w_short_abort) begin
          w_state_nxt = ST_OFF;
          w_load      = 1'b1;
          w_load_len  = r_active_toff;
        end
      end
      ST_OFF: begin
        if (w_stop_req) begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end else if (w_timer_done) begin
          w_state_nxt = ST_ON;
          w_load      = 1'b1;
          w_load_len  = w_eff_ton;
          w_enter_on  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_clear     = 1'b1;
      end
    endcase
  end

  // Shadow capture, pending tracking and boundary apply
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active_ton  <= DEF_TON;
      r_active_toff <= DEF_TOFF;
      r_active_ip   <= DEF_IP;
      r_active_wave <= DEF_WAVE;
      r_shadow_ton  <= '0;
      r_shadow_toff <= '0;
      r_shadow_ip   <= '0;
      r_shadow_wave <= '0;
      r_pending     <= '0;
    end else begin
      if (w_apply && r_pending[PEND_TON])  r_active_ton  <= r_shadow_ton;
      if (w_apply && r_pending[PEND_TOFF]) r_active_toff <= r_shadow_toff;
      if (w_apply && r_pending[PEND_IP])   r_active_ip   <= r_shadow_ip;
      if (w_apply && r_pending[PEND_WAVE]) r_active_wave <= r_shadow_wave;
      if (upd_ton)  r_shadow_ton  <= ton_in;
      if (upd_toff) r_shadow_toff <= toff_in;
      if (upd_ip)   r_shadow_ip   <= ip_in;
      if (upd_wave) r_shadow_wave <= wave_in;
      // A strobe in the apply clock survives the clear and waits for the next boundary
      r_pending <= (w_apply ? 4'b0000 : r_pending) | w_upd;
    end
  end

  // Registered strobes and ON-entry counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pulse_start <= 1'b0;
      r_param_err   <= 1'b0;
      r_pulse_cnt   <= '0;
    end else begin
      r_pulse_start <= w_enter_on;
      r_param_err   <= w_param_err_nxt;
      if (w_enter_on) r_pulse_cnt <= r_pulse_cnt + PARAM_W'(1);
    end
  end

  assign gate_on     = (r_state == ST_ON);
  assign running     = (r_state != ST_IDLE);
  assign pulse_start = r_pulse_start;
  assign param_err   = r_param_err;
  assign pulse_cnt   = r_pulse_cnt;
  assign pending     = r_pending;
  assign active_ton  = r_active_ton;
  assign active_toff = r_active_toff;
  assign active_ip   = r_active_ip;
  assign active_wave = r_active_wave;

endmodule

// File: tb/tb_discharge_pulse_scheduler.sv
// Self-checking bench for discharge_pulse_scheduler (TICK_DIV=2).
// Expected pulse records are queued as stimulus is driven; a negedge monitor
// pops one at every pulse_start and checks count, parameters and phase widths.
module tb_discharge_pulse_scheduler;

`ifdef SHORT_ABORT_EN
  localparam int SHORT_ON = 1;
`else
  localparam int SHORT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_spi, stop_spi, start_key, stop_key;
  logic        upd_ton, upd_toff, upd_ip, upd_wave;
  logic [15:0] ton_in, toff_in, ip_in, wave_in;
  logic        short_flag;
  logic        gate_on, pulse_start, running, param_err;
  logic [15:0] active_ton, active_toff, active_ip, active_wave, pulse_cnt;
  logic [3:0]  pending;

  typedef struct {
    int on_clks;
    int off_clks;
    int cnt;
    int ton;
    int ip;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur;
  int   on_run  = 0;
  int   off_run = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  discharge_pulse_scheduler #(
    .TICK_DIV (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_spi   (start_spi),
    .stop_spi    (stop_spi),
    .start_key   (start_key),
    .stop_key    (stop_key),
    .upd_ton     (upd_ton),
    .ton_in      (ton_in),
    .upd_toff    (upd_toff),
    .toff_in     (toff_in),
    .upd_ip      (upd_ip),
    .ip_in       (ip_in),
    .upd_wave    (upd_wave),
    .wave_in     (wave_in),
    .short_flag  (short_flag),
    .gate_on     (gate_on),
    .pulse_start (pulse_start),
    .running     (running),
    .active_ton  (active_ton),
    .active_toff (active_toff),
    .active_ip   (active_ip),
    .active_wave (active_wave),
    .pending     (pending),
    .pulse_cnt   (pulse_cnt),
    .param_err   (param_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input int on_c, input int off_c, input int cnt, input int ton, input int ip);
    rec_t r;
    r.on_clks  = on_c;
    r.off_clks = off_c;
    r.cnt      = cnt;
    r.ton      = ton;
    r.ip       = ip;
    exp_q.push_back(r);
  endtask

  task automatic wait_ps(input string tag);
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (pulse_start) break;
    end
    chk(tag, 32'(pulse_start), 32'd1);
  endtask

  // Pulse monitor: widths of ON/OFF runs and per-pulse state at pulse_start
  always @(negedge clk) begin
    if (!rst_n) begin
      on_run  = 0;
      off_run = 0;
    end else if (!running) begin
      if (on_run > 0) chk("on_len", 32'(on_run), 32'(cur.on_clks));
      on_run  = 0;
      off_run = 0;
    end else if (pulse_start) begin
      if (off_run > 0) chk("off_len", 32'(off_run), 32'(cur.off_clks));
      chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("pulse_cnt", 32'(pulse_cnt), 32'(cur.cnt));
        chk("pulse_ton", 32'(active_ton), 32'(cur.ton));
        chk("pulse_ip", 32'(active_ip), 32'(cur.ip));
      end
      on_run  = 1;
      off_run = 0;
    end else if (gate_on) begin
      on_run++;
    end else begin
      if (on_run > 0) begin
        chk("on_len", 32'(on_run), 32'(cur.on_clks));
        on_run = 0;
      end
      off_run++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {start_spi, stop_spi, start_key, stop_key} = '0;
    {upd_ton, upd_toff, upd_ip, upd_wave} = '0;
    ton_in = '0; toff_in = '0; ip_in = '0; wave_in = '0;
    short_flag = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    chk("rst_gate", 32'(gate_on), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_pstart", 32'(pulse_start), 32'd0);
    chk("rst_perr", 32'(param_err), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_cnt", 32'(pulse_cnt), 32'd0);
    chk("rst_ton", 32'(active_ton), 32'd5);
    chk("rst_toff", 32'(active_toff), 32'd20);
    chk("rst_ip", 32'(active_ip), 32'd0);
    chk("rst_wave", 32'(active_wave), 32'd0);

    // Ton=3, Toff=4 loaded while idle
    ton_in = 16'd3; toff_in = 16'd4; upd_ton = 1'b1; upd_toff = 1'b1;
    cyc();
    upd_ton = 1'b0; upd_toff = 1'b0;
    chk("idle_pending", 32'(pending), 32'h3);
    chk("idle_ton_not_yet", 32'(active_ton), 32'd5);
    cyc();
    chk("idle_ton_applied", 32'(active_ton), 32'd3);
    chk("idle_toff_applied", 32'(active_toff), 32'd4);
    chk("idle_pending_clr", 32'(pending), 32'd0);

    push_rec(6, 8, 1, 3, 0);
    push_rec(6, 8, 2, 3, 0);
    push_rec(20, 8, 3, 10, 0);
    start_key = 1'b1;
    cyc();
    start_key = 1'b0;
    chk("start_gate", 32'(gate_on), 32'd1);
    chk("start_pstart", 32'(pulse_start), 32'd1);
    chk("start_running", 32'(running), 32'd1);

    // Ton update mid-ON waits for the next ON entry
    wait_ps("ps2");
    ton_in = 16'd10; upd_ton = 1'b1;
    cyc();
    upd_ton = 1'b0;
    chk("midon_pending", 32'(pending), 32'h1);
    chk("midon_ton_kept", 32'(active_ton), 32'd3);
    wait_ps("ps3");
    chk("ps3_pending_clr", 32'(pending), 32'd0);
    chk("ps3_ton", 32'(active_ton), 32'd10);

    // Ip strobe exactly in the OFF->ON clock of pulse 4
    push_rec(20, 8, 4, 10, 0);
    push_rec(4, 0, 5, 10, 7);
    repeat (27) cyc();
    ip_in = 16'd7; upd_ip = 1'b1;
    cyc();
    upd_ip = 1'b0;
    chk("bnd_pstart", 32'(pulse_start), 32'd1);
    chk("bnd_pending", 32'(pending), 32'h4);
    chk("bnd_ip_kept", 32'(active_ip), 32'd0);
    wait_ps("ps5");
    chk("ps5_pending_clr", 32'(pending), 32'd0);
    chk("ps5_ip", 32'(active_ip), 32'd7);

    // Stop mid-ON
    repeat (3) cyc();
    stop_spi = 1'b1;
    cyc();
    stop_spi = 1'b0;
    chk("stop_gate", 32'(gate_on), 32'd0);
    chk("stop_running", 32'(running), 32'd0);
    chk("stop_cnt", 32'(pulse_cnt), 32'd5);

    // Simultaneous start and stop while idle: stop wins
    start_spi = 1'b1; stop_key = 1'b1;
    cyc();
    start_spi = 1'b0; stop_key = 1'b0;
    chk("ss_running", 32'(running), 32'd0);
    chk("ss_gate", 32'(gate_on), 32'd0);
    chk("ss_perr", 32'(param_err), 32'd0);

    // Toff=0 makes a start invalid
    toff_in = 16'd0; upd_toff = 1'b1;
    cyc();
    upd_toff = 1'b0;
    cyc();
    chk("zero_toff", 32'(active_toff), 32'd0);
    start_key = 1'b1;
    cyc();
    start_key = 1'b0;
    chk("perr_pulse", 32'(param_err), 32'd1);
    chk("perr_running", 32'(running), 32'd0);
    cyc();
    chk("perr_one_clk", 32'(param_err), 32'd0);
    chk("perr_gate", 32'(gate_on), 32'd0);

    // Start validated against the value applied in the same clock
    toff_in = 16'd4; upd_toff = 1'b1;
    cyc();
    upd_toff = 1'b0;
    push_rec((SHORT_ON != 0) ? 2 : 20, 8, 6, 10, 7);
    push_rec(1, 0, 7, 10, 7);
    start_key = 1'b1;
    cyc();
    start_key = 1'b0;
    chk("postapply_running", 32'(running), 32'd1);
    chk("postapply_toff", 32'(active_toff), 32'd4);
    chk("postapply_pending", 32'(pending), 32'd0);

    // short_flag in the second ON clock
    cyc();
    short_flag = 1'b1;
    cyc();
    short_flag = 1'b0;
    chk("short_gate", 32'(gate_on), (SHORT_ON != 0) ? 32'd0 : 32'd1);

    // Start while running is ignored
    start_spi = 1'b1;
    cyc();
    start_spi = 1'b0;
    chk("run_start_ignored", 32'(pulse_start), 32'd0);

    wait_ps("ps7");
    stop_key = 1'b1;
    cyc();
    stop_key = 1'b0;
    chk("stop2_running", 32'(running), 32'd0);
    chk("stop2_cnt", 32'(pulse_cnt), 32'd7);

    repeat (4) cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
